drive_sequencer: RTL and testbench
==================================

# drive_sequencer

Run-time controller for the fixed-frequency bridge driver. It latches a sweep profile on `start` and drives the driver's `freq`, `duty`, `phase`, `pos` and `neg` inputs through four phases: duty soft-start, frequency sweep, hold, and duty soft-stop. Every output is registered and changes only at dwell-timer ticks, so the driver's internal period/duty/phase recalculation always settles between updates. It sits between the host register file and the driver instance.

## Interface
- `FREQ_BITS`, 19, width of frequency words (driver frequency code)
- `DUTY_BITS`, 7, width of duty words
- `PHASE_BITS`, 9, width of phase word
- `DUTY_SCALE`, 100, full-scale duty; `cfg_duty` is clamped to this value
- `DWELL_BITS`, 24, width of dwell count in `clk` cycles

- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, asynchronous, active-high
- `start`  in  1  level, sampled in IDLE only
- `stop`  in  1  level, requests soft-stop
- `cfg_f_start` / `cfg_f_stop`  in  FREQ_BITS  sweep endpoints
- `cfg_f_step`  in  FREQ_BITS  frequency increment per dwell tick
- `cfg_duty`  in  DUTY_BITS  target duty
- `cfg_phase`  in  PHASE_BITS  phase passed through to the driver
- `cfg_dwell`  in  DWELL_BITS  cycles per step; 0 is treated as 1
- `freq`  out  FREQ_BITS  to driver
- `duty`  out  DUTY_BITS  to driver
- `phase`  out  PHASE_BITS  to driver
- `pos`, `neg`  out  1  driver output enables
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when soft-stop completes

## Operation
- **States:** IDLE, DUTY_UP, SWEEP, HOLD, DUTY_DN.
- **Reset values:** all outputs 0, state IDLE, dwell counter 0.
- **Latching:** `cfg_*` are latched only on the IDLE→DUTY_UP transition. Later changes to `cfg_*` have no effect until the next run.
- **IDLE:** if `start` is high, latch config and set `freq`=f_start, `duty`=0, `phase`=cfg_phase, `pos`=`neg`=1. Go to DUTY_UP.
- **Dwell timer:** counts 0..dwell-1 and emits a tick on the count dwell-1, then wraps to 0. It restarts at 0 on every state entry.
- **DUTY_UP:**
  - On each tick, `duty`+=1.
  - When `duty` equals the clamped target, go to SWEEP on the same tick.
  - If the target is 0, go to SWEEP on the first tick without incrementing.
- **SWEEP:**
  - Direction is up if f_stop ≥ f_start, otherwise down.
  - On each tick, `freq` moves by f_step toward f_stop and saturates at f_stop (no overshoot, no wrap).
  - Go to HOLD when `freq` == f_stop.
  - If f_step is 0, or f_start equals f_stop, go to HOLD on the first tick.
  - Compute the next frequency at FREQ_BITS+1 width so saturation is exact.
- **HOLD:** outputs stay static.
- **stop:** when sampled high in DUTY_UP, SWEEP or HOLD, go to DUTY_DN. `freq` is frozen at its current value and the timer restarts.
- **DUTY_DN:**
  - On each tick, `duty`-=1.
  - The tick that brings `duty` to 0 also clears `pos`/`neg`, pulses `done` and returns to IDLE.
  - If `duty` is already 0 on entry, this happens on the first tick.
- **Ignored inputs:** `start` outside IDLE and `stop` in IDLE/DUTY_DN are ignored.
- **start and stop both high in IDLE:** `start` wins. `stop` is evaluated from the next cycle, so the block enters DUTY_DN after one cycle in DUTY_UP.
- **Reset mid-run:** all outputs drop to 0 asynchronously. No soft-stop and no `done`.

## Timing
- `start` sampled at edge N: `busy`, `pos`, `neg` and `freq`=f_start are visible after edge N.
- The first duty step lands at edge N+dwell. Each later step is dwell cycles after the previous one.
- The SWEEP timer starts at the edge where DUTY_UP exits, so the first frequency step lands dwell cycles after that edge.
- `stop` sampled at edge M: the state is DUTY_DN after M. The first decrement lands at M+dwell.
- `done` is high for exactly the cycle in which `busy` first reads 0.
- Outputs never change between ticks, apart from state-entry loads.

## Structure
- Package `drive_seq_pkg` holds:
  - the `drive_seq_state_t` enum (logic [2:0]);
  - the default width constants.
- Sub-module `dwell_timer`:
  - ports: clk, rst, clr, dwell in; tick out;
  - treats dwell 0 as 1;
  - reused by other profile blocks.
- The top module holds the FSM and the frequency/duty arithmetic.

## Test plan
- **Basic run:** dwell=4, duty 3, f 1000→1010 step 5, phase 90.
  - duty 1,2,3 at ticks 4/8/12 after start;
  - freq 1005 at +16, 1010 at +20, then HOLD;
  - `phase` stays 90 throughout.
- **Saturation and down-sweep:** f 1000→1012 step 5 gives 1005, 1010, 1012 (clamped). f 2000→1990 step 4 gives 1996, 1992, 1990.
- **Soft-stop from HOLD:** `stop` in HOLD with duty 3, dwell 4.
  - duty 2,1,0 at +4/+8/+12;
  - `pos`/`neg`=0, `done` single pulse and `busy`=0 at +12.
- **Early stop:** `stop` during SWEEP at freq 1005 → freq stays 1005 through DUTY_DN.
- **Degenerate inputs:**
  - dwell=0 behaves as dwell=1;
  - cfg_duty=120 clamps to 100;
  - f_step=0 goes to HOLD on the first SWEEP tick.
- **Async reset mid-run:** `rst` asserted mid-SWEEP → all outputs 0 immediately, state IDLE, no `done`. A new `start` after release runs normally.

Source files
------------

// File: rtl/drive_seq_pkg.sv
// Shared types and default widths for the bridge-driver profile sequencer.
// Imported by the sequencer top and its dwell timer.
package drive_seq_pkg;

  localparam int FREQ_BITS_DEF  = 19;
  localparam int DUTY_BITS_DEF  = 7;
  localparam int PHASE_BITS_DEF = 9;
  localparam int DUTY_SCALE_DEF = 100;
  localparam int DWELL_BITS_DEF = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUTY_UP,
    S_SWEEP,
    S_HOLD,
    S_DUTY_DN
  } drive_seq_state_t;

endpackage

// File: rtl/dwell_timer.sv
// Free-running step timer: ticks every dwell cycles (0 acts as 1).
// A clear restarts the count so the first tick lands dwell cycles later.
module dwell_timer
  import drive_seq_pkg::*;
#(
  parameter int DWELL_BITS = DWELL_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DWELL_BITS-1:0] dwell,
  output logic                  tick
);

  logic [DWELL_BITS-1:0] cnt_q;
  logic [DWELL_BITS-1:0] cnt_d;
  logic [DWELL_BITS-1:0] last;

  always_comb begin
    last = '0;
    if (dwell != '0) last = dwell - DWELL_BITS'(1);
    tick  = (cnt_q == last);
    cnt_d = cnt_q + DWELL_BITS'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/drive_sequencer.sv
// Soft-start / sweep / hold / soft-stop controller for the bridge driver.
// All driver-facing outputs are flops that move only on dwell ticks.
module drive_sequencer
  import drive_seq_pkg::*;
#(
  parameter int FREQ_BITS  = FREQ_BITS_DEF,
  parameter int DUTY_BITS  = DUTY_BITS_DEF,
  parameter int PHASE_BITS = PHASE_BITS_DEF,
  parameter int DUTY_SCALE = DUTY_SCALE_DEF,
  parameter int DWELL_BITS = DWELL_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [FREQ_BITS-1:0]  cfg_f_start,
  input  logic [FREQ_BITS-1:0]  cfg_f_stop,
  input  logic [FREQ_BITS-1:0]  cfg_f_step,
  input  logic [DUTY_BITS-1:0]  cfg_duty,
  input  logic [PHASE_BITS-1:0] cfg_phase,
  input  logic [DWELL_BITS-1:0] cfg_dwell,
  output logic [FREQ_BITS-1:0]  freq,
  output logic [DUTY_BITS-1:0]  duty,
  output logic [PHASE_BITS-1:0] phase,
  output logic                  pos,
  output logic                  neg,
  output logic                  busy,
  output logic                  done
);

  drive_seq_state_t state_q, state_d;

  logic [FREQ_BITS-1:0]  freq_q, freq_d;
  logic [DUTY_BITS-1:0]  duty_q, duty_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [FREQ_BITS-1:0]  f_stop_q, f_stop_d;
  logic [FREQ_BITS-1:0]  f_step_q, f_step_d;
  logic [DUTY_BITS-1:0]  tgt_q, tgt_d;
  logic [DWELL_BITS-1:0] dwell_q, dwell_d;
  logic                  up_q, up_d;

  logic                  tick;
  logic                  clr;
  logic [DUTY_BITS-1:0]  duty_inc;
  logic [DUTY_BITS-1:0]  duty_dec;
  logic [FREQ_BITS:0]    f_up;
  logic [FREQ_BITS:0]    f_dn;
  logic [FREQ_BITS-1:0]  f_nxt;

  assign clr = (state_d != state_q);

  dwell_timer #(
    .DWELL_BITS (DWELL_BITS)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .dwell (dwell_q),
    .tick  (tick)
  );

  // One extra bit so the step can never wrap past either rail.
  always_comb begin
    f_up  = {1'b0, freq_q} + {1'b0, f_step_q};
    f_dn  = {1'b0, freq_q} - {1'b0, f_step_q};
    f_nxt = f_stop_q;
    if (up_q) begin
      if (f_up < {1'b0, f_stop_q})
        f_nxt = f_up[FREQ_BITS-1:0];
    end else begin
      if (!f_dn[FREQ_BITS] &&
          f_dn[FREQ_BITS-1:0] > f_stop_q)
        f_nxt = f_dn[FREQ_BITS-1:0];
    end
    duty_inc = duty_q + DUTY_BITS'(1);
    duty_dec = duty_q - DUTY_BITS'(1);
  end

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    en_d     = en_q;
    done_d   = 1'b0;
    f_stop_d = f_stop_q;
    f_step_d = f_step_q;
    tgt_d    = tgt_q;
    dwell_d  = dwell_q;
    up_d     = up_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          f_stop_d = cfg_f_stop;
          f_step_d = cfg_f_step;
          dwell_d  = cfg_dwell;
          up_d     = (cfg_f_stop >= cfg_f_start);
          tgt_d    = cfg_duty;
          if (cfg_duty > DUTY_BITS'(DUTY_SCALE))
            tgt_d = DUTY_BITS'(DUTY_SCALE);
          freq_d   = cfg_f_start;
          duty_d   = '0;
          phase_d  = cfg_phase;
          en_d     = 1'b1;
          state_d  = S_DUTY_UP;
        end
      end
      S_DUTY_UP: begin
        if (stop) begin
          state_d = S_DUTY_DN;
        end else if (tick) begin
          if (tgt_q == '0) begin
            state_d = S_SWEEP;
          end else begin
            duty_d = duty_inc;
            if (duty_inc == tgt_q) state_d = S_SWEEP;
          end
        end
      end
      S_SWEEP: begin
        if (stop) begin
          state_d = S_DUTY_DN;
        end else if (tick) begin
          if (f_step_q == '0 || freq_q == f_stop_q) begin
            state_d = S_HOLD;
          end else begin
            freq_d = f_nxt;
            if (f_nxt == f_stop_q) state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (stop) state_d = S_DUTY_DN;
      end
      S_DUTY_DN: begin
        if (tick) begin
          if (duty_q <= DUTY_BITS'(1)) begin
            duty_d  = '0;
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            duty_d = duty_dec;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      freq_q   <= '0;
      duty_q   <= '0;
      phase_q  <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      f_stop_q <= '0;
      f_step_q <= '0;
      tgt_q    <= '0;
      dwell_q  <= '0;
      up_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      f_stop_q <= f_stop_d;
      f_step_q <= f_step_d;
      tgt_q    <= tgt_d;
      dwell_q  <= dwell_d;
      up_q     <= up_d;
    end
  end

  assign freq  = freq_q;
  assign duty  = duty_q;
  assign phase = phase_q;
  assign pos   = en_q;
  assign neg   = en_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: profile table plus scoreboarded
// expectations keyed on the cycle they must appear.
module tb_drive_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [18:0] cfg_f_start = '0;
  logic [18:0] cfg_f_stop = '0;
  logic [18:0] cfg_f_step = '0;
  logic [6:0]  cfg_duty = '0;
  logic [8:0]  cfg_phase = '0;
  logic [23:0] cfg_dwell = '0;
  logic [18:0] freq;
  logic [6:0]  duty;
  logic [8:0]  phase;
  logic        pos, neg, busy, done;

  drive_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .cfg_f_start (cfg_f_start),
    .cfg_f_stop  (cfg_f_stop),
    .cfg_f_step  (cfg_f_step),
    .cfg_duty    (cfg_duty),
    .cfg_phase   (cfg_phase),
    .cfg_dwell   (cfg_dwell),
    .freq        (freq),
    .duty        (duty),
    .phase       (phase),
    .pos         (pos),
    .neg         (neg),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    int at;
    int id;
    logic [38:0] v;
  } exp_t;

  typedef struct packed {
    int dwell;
    int duty;
    int f0;
    int f1;
    int fs;
    int ph;
    int tgt;
    int stop_off;
    int stop_f;
  } vec_t;

  typedef struct packed {
    int vi;
    int off;
    int f;
    int d;
  } pt_t;

  exp_t sb[$];
  vec_t vt[$];
  pt_t  pts[$];

  function automatic logic [38:0] ev(
    int f, int d, int ph, bit pn, bit b, bit dn);
    return {19'(f), 7'(d), 9'(ph), pn, pn, b, dn};
  endfunction

  function automatic logic [38:0] act();
    return {freq, duty, phase, pos, neg, busy, done};
  endfunction

  task automatic chk(string tag, logic [38:0] a,
                     logic [38:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, a, e);
    end
  endtask

  task automatic push(int at, int id, logic [38:0] v);
    sb.push_back('{at: at, id: id, v: v});
  endtask

  // Compares every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.at != cyc || act() !== e.v) begin
        failures++;
        $display("FAIL v%0d.p%0d cyc=%0d at=%0d got=%h want=%h",
                 e.id / 1000, e.id % 1000, cyc, e.at,
                 act(), e.v);
      end
    end
  end

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic begin_run(int dw, int du, int f0, int f1,
                           int fs, int ph, output int n0);
    @(negedge clk);
    cfg_dwell   = 24'(dw);
    cfg_duty    = 7'(du);
    cfg_f_start = 19'(f0);
    cfg_f_stop  = 19'(f1);
    cfg_f_step  = 19'(fs);
    cfg_phase   = 9'(ph);
    start = 1'b1;
    n0 = cyc + 1;
  endtask

  // Garbage on cfg_* after the start edge must not leak in.
  task automatic scramble();
    start       = 1'b0;
    cfg_dwell   = 24'($urandom_range(1, 9));
    cfg_duty    = 7'($urandom);
    cfg_f_start = 19'($urandom);
    cfg_f_stop  = 19'($urandom);
    cfg_f_step  = 19'($urandom);
    cfg_phase   = 9'($urandom);
  endtask

  task automatic run_vec(int i);
    vec_t v;
    int n0, m, dw, d_at, tg;
    v = vt[i];
    begin_run(v.dwell, v.duty, v.f0, v.f1, v.fs, v.ph, n0);
    foreach (pts[j])
      if (pts[j].vi == i)
        push(n0 + pts[j].off, i * 1000 + j,
             ev(pts[j].f, pts[j].d, v.ph, 1, 1, 0));
    dw = (v.dwell == 0) ? 1 : v.dwell;
    tg = v.tgt;
    m  = n0 + v.stop_off;
    for (int k = 1; k < tg; k++) begin
      push(m + k * dw - 1, i * 1000 + 500 + k,
           ev(v.stop_f, tg - k + 1, v.ph, 1, 1, 0));
      push(m + k * dw, i * 1000 + 500 + k,
           ev(v.stop_f, tg - k, v.ph, 1, 1, 0));
    end
    d_at = m + ((tg == 0) ? 1 : tg) * dw;
    push(d_at - 1, i * 1000 + 900,
         ev(v.stop_f, (tg == 0) ? 0 : 1, v.ph, 1, 1, 0));
    push(d_at, i * 1000 + 901,
         ev(v.stop_f, 0, v.ph, 0, 0, 1));
    push(d_at + 1, i * 1000 + 902,
         ev(v.stop_f, 0, v.ph, 0, 0, 0));
    wait_to(n0);
    scramble();
    wait_to(m - 1);
    stop = 1'b1;
    wait_to(m);
    stop = 1'b0;
    wait_to(d_at + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, m;

    // dwell, duty, f0, f1, step, phase, tgt, stop_off, stop_f
    vt.push_back('{4, 3, 1000, 1010, 5, 90, 3, 32, 1010});
    vt.push_back('{4, 1, 1000, 1012, 5, 7, 1, 26, 1012});
    vt.push_back('{4, 1, 2000, 1990, 4, 300, 1, 26, 1990});
    vt.push_back('{0, 2, 1000, 1010, 10, 1, 2, 8, 1010});
    vt.push_back('{0, 120, 500, 500, 1, 511, 100, 112, 500});
    vt.push_back('{2, 1, 300, 400, 0, 45, 1, 12, 300});
    vt.push_back('{1, 1, 524280, 524287, 5, 3, 1, 8, 524287});
    vt.push_back('{1, 1, 7, 0, 5, 2, 1, 7, 0});

    // vector, offset from start edge, freq, duty
    pts.push_back('{0, 0, 1000, 0});
    pts.push_back('{0, 3, 1000, 0});
    pts.push_back('{0, 4, 1000, 1});
    pts.push_back('{0, 8, 1000, 2});
    pts.push_back('{0, 12, 1000, 3});
    pts.push_back('{0, 15, 1000, 3});
    pts.push_back('{0, 16, 1005, 3});
    pts.push_back('{0, 20, 1010, 3});
    pts.push_back('{0, 30, 1010, 3});
    pts.push_back('{1, 0, 1000, 0});
    pts.push_back('{1, 4, 1000, 1});
    pts.push_back('{1, 7, 1000, 1});
    pts.push_back('{1, 8, 1005, 1});
    pts.push_back('{1, 12, 1010, 1});
    pts.push_back('{1, 16, 1012, 1});
    pts.push_back('{1, 24, 1012, 1});
    pts.push_back('{2, 0, 2000, 0});
    pts.push_back('{2, 4, 2000, 1});
    pts.push_back('{2, 8, 1996, 1});
    pts.push_back('{2, 12, 1992, 1});
    pts.push_back('{2, 16, 1990, 1});
    pts.push_back('{2, 24, 1990, 1});
    pts.push_back('{3, 0, 1000, 0});
    pts.push_back('{3, 1, 1000, 1});
    pts.push_back('{3, 2, 1000, 2});
    pts.push_back('{3, 3, 1010, 2});
    pts.push_back('{3, 6, 1010, 2});
    pts.push_back('{4, 0, 500, 0});
    pts.push_back('{4, 50, 500, 50});
    pts.push_back('{4, 99, 500, 99});
    pts.push_back('{4, 100, 500, 100});
    pts.push_back('{4, 101, 500, 100});
    pts.push_back('{4, 110, 500, 100});
    pts.push_back('{5, 0, 300, 0});
    pts.push_back('{5, 1, 300, 0});
    pts.push_back('{5, 2, 300, 1});
    pts.push_back('{5, 4, 300, 1});
    pts.push_back('{5, 10, 300, 1});
    pts.push_back('{6, 0, 524280, 0});
    pts.push_back('{6, 1, 524280, 1});
    pts.push_back('{6, 2, 524285, 1});
    pts.push_back('{6, 3, 524287, 1});
    pts.push_back('{6, 6, 524287, 1});
    pts.push_back('{7, 0, 7, 0});
    pts.push_back('{7, 1, 7, 1});
    pts.push_back('{7, 2, 2, 1});
    pts.push_back('{7, 3, 0, 1});
    pts.push_back('{7, 5, 0, 1});

    #1 rst = 1'b1;
    #1 chk("reset_state", act(), ev(0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", act(), ev(0, 0, 0, 0, 0, 0));

    foreach (vt[i]) run_vec(i);

    // Stop mid-sweep: freq freezes at 1005 through soft-stop.
    begin_run(4, 1, 1000, 1020, 5, 10, n0);
    m = n0 + 10;
    push(n0 + 4, 20001, ev(1000, 1, 10, 1, 1, 0));
    push(n0 + 9, 20002, ev(1005, 1, 10, 1, 1, 0));
    push(m + 2, 20003, ev(1005, 1, 10, 1, 1, 0));
    push(m + 3, 20004, ev(1005, 1, 10, 1, 1, 0));
    push(m + 4, 20005, ev(1005, 0, 10, 0, 0, 1));
    push(m + 5, 20006, ev(1005, 0, 10, 0, 0, 0));
    wait_to(n0);
    scramble();
    wait_to(m - 1);
    stop = 1'b1;
    wait_to(m);
    stop = 1'b0;
    wait_to(m + 7);

    // start and stop together: one cycle of DUTY_UP, then DUTY_DN.
    begin_run(4, 3, 50, 60, 1, 5, n0);
    stop = 1'b1;
    push(n0, 21001, ev(50, 0, 5, 1, 1, 0));
    push(n0 + 4, 21002, ev(50, 0, 5, 1, 1, 0));
    push(n0 + 5, 21003, ev(50, 0, 5, 0, 0, 1));
    push(n0 + 6, 21004, ev(50, 0, 5, 0, 0, 0));
    wait_to(n0);
    start = 1'b0;
    wait_to(n0 + 1);
    stop = 1'b0;
    wait_to(n0 + 8);

    // Async reset mid-sweep, then a clean rerun.
    begin_run(4, 3, 1000, 1010, 5, 90, n0);
    push(n0 + 12, 22001, ev(1000, 3, 90, 1, 1, 0));
    push(n0 + 16, 22002, ev(1005, 3, 90, 1, 1, 0));
    wait_to(n0);
    scramble();
    wait_to(n0 + 18);
    #2 rst = 1'b1;
    #1 chk("async_rst_now", act(), ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst_held", act(), ev(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_done", act(), ev(0, 0, 0, 0, 0, 0));
    run_vec(0);

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
